// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared definitions for the adder arbiter:
//   - FSM state type and encodings (IDLE, EXEC, RESP)
//   - clog2 helper used to size the requester ID
package adder_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

  // Ceiling log2, floored at 1 so a 1-bit ID still exists for two requesters.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder.sv
// adder
// Ripple-carry adder: {co, s} = a + b + ci.
// Ports:
//   a, b  in  DATA_WIDTH  operands
//   ci    in  1           carry-in
//   s     out DATA_WIDTH  sum
//   co    out 1           carry-out
module adder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co
);

  logic [DATA_WIDTH:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[DATA_WIDTH];

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req upward starting at ptr,
// wrapping at NUM_REQ-1, and returns the first asserted requester.
// Ports:
//   req  in  NUM_REQ  request levels
//   ptr  in  ID_W     highest-priority index for this search
//   gnt  out NUM_REQ  one-hot winner (all zero when req is zero)
//   idx  out ID_W     winner index (zero when req is zero)
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned ID_W = clog2(NUM_REQ);
  localparam logic [ID_W:0] NumReqW = (ID_W + 1)'(NUM_REQ);

  // One extra bit holds ptr+i before the wrap; ptr < NUM_REQ so one
  // subtraction is enough.
  logic [ID_W:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!found && req[cand[ID_W-1:0]]) begin
        found                 = 1'b1;
        idx                   = cand[ID_W-1:0];
        gnt[cand[ID_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter sharing one adder among NUM_REQ requesters. In IDLE a
// winner is picked and its operands captured; EXEC runs the adder and
// registers the result; RESP holds the result until READY.
// Ports:
//   CLK, RST_N       clock, async active-low reset
//   REQ              per-requester request level
//   A_IN, B_IN       packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   CI_IN            per-requester carry-in
//   GNT              one-hot pulse in the cycle after capture
//   S, CO, ID        registered sum, carry-out and owning requester
//   VALID, READY     result handshake
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] A_IN,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] B_IN,
  input  logic [NUM_REQ-1:0]            CI_IN,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [DATA_WIDTH-1:0]         S,
  output logic                          CO,
  output logic [clog2(NUM_REQ)-1:0]     ID,
  output logic                          VALID,
  input  logic                          READY
);

  localparam int unsigned ID_W = clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       win_q, win_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_ci_q, op_ci_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic                  co_q, co_d;
  logic                  valid_q, valid_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [ID_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  sel_ci;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  adder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a  (op_a_q),
    .b  (op_b_q),
    .ci (op_ci_q),
    .s  (sum),
    .co (cout)
  );

  // One-hot operand mux driven by the picker's grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_ci = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_gnt[i]) begin
        sel_a  = A_IN[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = B_IN[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ci = CI_IN[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_ci_d = op_ci_q;
    s_d     = s_q;
    co_d    = co_q;
    id_d    = id_q;
    valid_d = valid_q;
    gnt_d   = '0;  // GNT is a single-cycle pulse
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          op_ci_d = sel_ci;
          gnt_d   = pick_gnt;
          win_d   = pick_idx;
          ptr_d   = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = sum;
        co_d    = cout;
        id_d    = win_q;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_ci_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_ci_q <= op_ci_d;
      s_q     <= s_d;
      co_q    <= co_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign S     = s_q;
  assign CO    = co_q;
  assign ID    = id_q;
  assign VALID = valid_q;

endmodule
